// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - limb-serial A-B subtractor with S1/S2 pipeline; option SEQ_SUBTRACTOR_ZERO_FLAG_EN adds out_zero
module seq_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             out_borrow,
    output logic             out_last,
    output logic             protocol_err
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CHAIN = 1'b1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_first;
    logic             s1_last;
    logic [0:0]       state;
    logic             borrow_q;

    logic             s2_ready;
    logic             s1_move;
    logic             accept;
    logic             eff_first;
    logic             bin;
    logic             err;
    logic [WIDTH:0]   sub;

    assign s2_ready = !out_valid || out_ready;
    assign s1_move  = s1_valid && s2_ready;
    assign in_ready = !rst && (!s1_valid || s2_ready);
    assign accept   = in_valid && in_ready;

    // A limb arriving in IDLE always starts a chain, with or without its first flag.
    always_comb begin
        eff_first = s1_first || (state == ST_IDLE);
        bin       = eff_first ? 1'b0 : borrow_q;
        err       = (state == ST_IDLE) ? !s1_first : s1_first;
        sub       = {1'b0, s1_a} - {1'b0, s1_b} - {{WIDTH{1'b0}}, bin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            state        <= ST_IDLE;
            borrow_q     <= 1'b0;
            out_valid    <= 1'b0;
            diff         <= '0;
            out_borrow   <= 1'b0;
            out_last     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= input_a;
                s1_b     <= input_b;
                s1_first <= in_first;
                s1_last  <= in_last;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s1_move) begin
                out_valid    <= 1'b1;
                diff         <= sub[WIDTH-1:0];
                out_borrow   <= sub[WIDTH];
                out_last     <= s1_last;
                protocol_err <= err;
                borrow_q     <= s1_last ? 1'b0 : sub[WIDTH];
                state        <= s1_last ? ST_IDLE : ST_CHAIN;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                protocol_err <= 1'b0;
            end
        end
    end

`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
    logic zero_acc;
    logic zero_next;

    assign zero_next = (eff_first || zero_acc) && (sub[WIDTH-1:0] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_acc <= 1'b0;
            out_zero <= 1'b0;
        end else if (s1_move) begin
            zero_acc <= zero_next;
            out_zero <= s1_last && zero_next;
        end
    end
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - directed self-checking bench for seq_subtractor (define SEQ_SUBTRACTOR_ZERO_FLAG_EN for out_zero checks)
module tb_seq_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] input_a;
    logic [7:0] input_b;
    logic       in_first;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       out_borrow;
    logic       out_last;
    logic       protocol_err;
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int errors = 0;
    int checks = 0;

    seq_subtractor #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_a      (input_a),
        .input_b      (input_b),
        .in_first     (in_first),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .diff         (diff),
        .out_borrow   (out_borrow),
        .out_last     (out_last),
        .protocol_err (protocol_err)
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
        ,
        .out_zero     (out_zero)
`endif
    );

    always #5 clk = ~clk;

    // Streaming vectors: 16'h1234-16'h0235, 8'h80-8'h7F, 24'h0-24'h1, 16'hFF00-16'h00FF
    logic [7:0] va  [8] = '{8'h34, 8'h12, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] vb  [8] = '{8'h35, 8'h02, 8'h7F, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00};
    logic       vf  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       vl  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] vd  [8] = '{8'hFF, 8'h0F, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFE};
    logic       vbo [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one limb and returns just after the edge that accepted it.
    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        @(posedge clk);
        #1;
        input_a  = a;
        input_b  = b;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic bo,
                              input logic la, input logic pe);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(d));
        check({tag, "_borrow"}, 32'(out_borrow), 32'(bo));
        check({tag, "_last"}, 32'(out_last), 32'(la));
        check({tag, "_perr"}, 32'(protocol_err), 32'(pe));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        input_a   = '0;
        input_b   = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(out_borrow), 32'd0);
        check("reset_last", 32'(out_last), 32'd0);
        check("reset_perr", 32'(protocol_err), 32'd0);
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
        check("reset_zero", 32'(out_zero), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Non-first limb straight after reset: flagged, computed with bin=0.
        put(8'h05, 8'h03, 1'b0, 1'b1);
        expect_out("nofirst", 8'h02, 1'b0, 1'b1, 1'b1);

        // Single limb with latency: S1 after the accepting edge, output after the next.
        put(8'h05, 8'h03, 1'b1, 1'b1);
        check("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_diff", 32'(diff), 32'h02);
        check("lat_borrow", 32'(out_borrow), 32'd0);
        check("lat_last", 32'(out_last), 32'd1);
        check("lat_perr", 32'(protocol_err), 32'd0);

        put(8'h00, 8'h01, 1'b1, 1'b1);
        expect_out("underflow", 8'hFF, 1'b1, 1'b1, 1'b0);
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
        check("underflow_zero", 32'(out_zero), 32'd0);
`endif

        put(8'h00, 8'h01, 1'b1, 1'b0);
        expect_out("two_lo", 8'hFF, 1'b1, 1'b0, 1'b0);
        put(8'h01, 8'h00, 1'b0, 1'b1);
        expect_out("two_hi", 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
        check("two_zero", 32'(out_zero), 32'd0);
`endif

        // Second first limb mid-chain restarts with bin=0 (02, not 01).
        put(8'h00, 8'h01, 1'b1, 1'b0);
        expect_out("dbl_a", 8'hFF, 1'b1, 1'b0, 1'b0);
        put(8'h05, 8'h03, 1'b1, 1'b0);
        expect_out("dbl_b", 8'h02, 1'b0, 1'b0, 1'b1);
        put(8'h00, 8'h00, 1'b0, 1'b1);
        expect_out("dbl_c", 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset while the first limb (with borrow) sits in S1.
        put(8'h00, 8'h01, 1'b1, 1'b0);
        do_reset();
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("flush_valid_later", 32'(out_valid), 32'd0);
        put(8'h10, 8'h10, 1'b1, 1'b1);
        expect_out("after_rst", 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
        check("after_rst_zero", 32'(out_zero), 32'd1);
`endif

        // Back-to-back operands with out_ready pattern 1,0,0,1.
        begin
            bit         stop;
            int         rx;
            stop = 1'b0;
            rx   = 0;
            fork
                begin
                    for (int i = 0; i < 8; i++) put(va[i], vb[i], vf[i], vl[i]);
                end
                begin
                    bit [3:0] pat;
                    int       k;
                    pat = 4'b1001;
                    k   = 0;
                    while (!stop) begin
                        @(posedge clk);
                        #1;
                        out_ready = pat[k % 4];
                        k++;
                    end
                    out_ready = 1'b1;
                end
                begin
                    int         cyc;
                    bit         stalled;
                    logic [7:0] hold_d;
                    logic       hold_b;
                    logic       hold_l;
                    cyc     = 0;
                    stalled = 1'b0;
                    hold_d  = '0;
                    hold_b  = 1'b0;
                    hold_l  = 1'b0;
                    while (rx < 8 && cyc < 400) begin
                        @(negedge clk);
                        cyc++;
                        if (stalled) begin
                            check("stall_valid", 32'(out_valid), 32'd1);
                            check("stall_diff", 32'(diff), 32'(hold_d));
                            check("stall_borrow", 32'(out_borrow), 32'(hold_b));
                            check("stall_last", 32'(out_last), 32'(hold_l));
                        end
                        if (!in_ready) check("ready_only_when_full", 32'(out_valid && !out_ready), 32'd1);
                        if (out_valid && out_ready) begin
                            check("stream_diff", 32'(diff), 32'(vd[rx]));
                            check("stream_borrow", 32'(out_borrow), 32'(vbo[rx]));
                            check("stream_last", 32'(out_last), 32'(vl[rx]));
                            rx++;
                        end
                        stalled = out_valid && !out_ready;
                        hold_d  = diff;
                        hold_b  = out_borrow;
                        hold_l  = out_last;
                    end
                    stop = 1'b1;
                end
            join
            check("stream_count", 32'(rx), 32'd8);
            repeat (3) @(negedge clk);
            check("stream_no_extra", 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
